approx_adder_pipe: RTL

// Parametrised pipelined approximate adder, successor to the fixed-width factorised approximate adders.

---
 rtl/approx_adder_pipe.sv | 99 +++++++++
 1 files changed

// File: rtl/approx_adder_pipe.sv
// approx_adder_pipe: two-stage valid/ready adder with exact, lower-part-OR and truncation modes,
// plus a saturating error monitor comparing every delivered result against the exact sum.
module approx_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int APPROX_BITS = 3,
  parameter int CNT_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_err,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_count,
  output logic [CNT_W-1:0] stat_err_cnt,
  output logic [ACC_W-1:0] stat_abs_err
);
  localparam int S = WIDTH + 1;
  localparam int K = APPROX_BITS;
  localparam int KM = (K > 0) ? K - 1 : 0;
  localparam int AW = ((ACC_W > S) ? ACC_W : S) + 1;
  generate
    if (K < 0 || K > WIDTH) begin : g_bad_k
      $error("APPROX_BITS must lie in 0..WIDTH");
    end
  endgenerate
  logic [S-1:0] ea, eb, mask, exact, loa, trn, approx, d;
  logic [S-1:0] s1_exact, s1_approx, s2_diff;
  logic [AW-1:0] acc_nx, acc_max;
  logic carry, s1_valid, s1_load, s2_load, out_hs;
  assign s2_load = !out_valid || out_ready;
  assign s1_load = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign out_hs = out_valid && out_ready;
  always_comb begin
    ea = S'(in_a);
    eb = S'(in_b);
    mask = ~({S{1'b1}} << K);
    carry = (K > 0) && in_a[KM] && in_b[KM];
    exact = ea + eb + S'(in_cin);
    loa = ((((ea >> K) + (eb >> K) + S'(carry)) << K)) | ((ea | eb) & mask);
    trn = ((ea >> K) + (eb >> K)) << K;
    // modes 0 and 3 (equal mode bits) and K=0 always take the exact sum
    approx = (K == 0 || in_mode[1] == in_mode[0]) ? exact : (in_mode[0] ? loa : trn);
    d = (s1_exact >= s1_approx) ? s1_exact - s1_approx : s1_approx - s1_exact;
    acc_nx = AW'(stat_abs_err) + AW'(s2_diff);
    acc_max = AW'({ACC_W{1'b1}});
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_exact <= '0;
      s1_approx <= '0;
      out_valid <= 1'b0;
      out_sum <= '0;
      out_err <= 1'b0;
      s2_diff <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_exact <= exact;
          s1_approx <= approx;
        end
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_sum <= s1_approx;
          out_err <= s1_approx != s1_exact;
          s2_diff <= d;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_count <= '0;
      stat_err_cnt <= '0;
      stat_abs_err <= '0;
    end else if (stat_clr) begin
      stat_count <= '0;
      stat_err_cnt <= '0;
      stat_abs_err <= '0;
    end else if (out_hs) begin
      stat_count <= stat_count + CNT_W'(~&stat_count);
      stat_err_cnt <= stat_err_cnt + CNT_W'(out_err && !(&stat_err_cnt));
      stat_abs_err <= (acc_nx > acc_max) ? {ACC_W{1'b1}} : acc_nx[ACC_W-1:0];
    end
  end
endmodule
